ota_stim_meas: RTL
==================

# ota_stim_meas

Digital stimulus-and-readback block for the on-chip digital OTA. It generates the two differential PWM drive signals that feed the OTA inputs (Vip, Vin) and samples the OTA output back to produce a per-frame high-time count. It sits beside the OTA inside the same tile. Its outputs are routed to the OTA input pins, and the OTA output pin returns to `ota_out`.

## Interface
Parameters:
- `PRESC_W`, default 4: width of the prescaler reload register. Legal range is 1–8.

Ports:
- `clk`, in, 1: single clock. Every flop in the block is on this clock.
- `rst_n`, in, 1: reset. Synchronous and active-low.
- `ena`, in, 1: global enable. While low, all counters hold and all outputs hold their values.
- `cfg_data`, in, 8: configuration write data.
- `cfg_sel`, in, 2: configuration register select.
  - 0 = `duty_p`
  - 1 = `duty_n`
  - 2 = `presc` (low `PRESC_W` bits used)
  - 3 = `ctrl` (bit0 `run`, bit1 `inv_n`)
- `cfg_we`, in, 1: single-cycle write strobe. Sampled only when `ena` = 1.
- `ota_out`, in, 1: OTA output. Asynchronous to `clk`.
- `vip_o`, out, 1: PWM drive to the OTA Vip input.
- `vin_o`, out, 1: PWM drive to the OTA Vin input.
- `frame_o`, out, 1: one-cycle pulse at the end of each frame.
- `meas_o`, out, 8: count of `ota_out` high samples in the last completed frame.
- `meas_valid_o`, out, 1: level. High once at least one complete frame has been measured since `run` was last set.

## Operation
- **Prescaler.** `pcnt` counts 0..`presc` and then wraps. `tick` is asserted in the cycle where `pcnt` == `presc`. With `presc` = 0, `tick` is asserted every cycle.
- **Phase counter.** `phase` is 8 bits and increments on `tick`, wrapping 255→0. A frame is 256 ticks long. The frame-end condition is `tick` && `phase` == 255.
- **PWM generation.**
  - `vip_o` <= `run` && (`phase` < `duty_p_act`).
  - `vin_o` <= `run` && ((`phase` < `duty_n_act`) XOR `inv_n`).
  - Duty 0 gives a constant 0. Duty 255 gives 255/256 high. Both outputs are registered.
- **Shadowing.**
  - Writes to `duty_p` and `duty_n` land in shadow registers.
  - Shadow values are copied to the active registers at frame end.
  - If `run` = 0, shadow values are copied on the cycle after the write.
  - A write in the same cycle as frame end is applied at that boundary (the incoming data goes straight to the active register).
  - Writes to `presc` and `ctrl` take effect on the next cycle, unshadowed.
- **Input sampler.** `ota_out` passes through a 2-flop synchronizer to give `ota_s`.
- **Accumulator.** On each `tick`, `acc` <= sat255(`acc` + `ota_s`).
- **Frame end.** At frame end:
  - `meas_o` <= sat255(`acc` + `ota_s`).
  - `acc` <= 0.
  - `frame_o` = 1 for one cycle.
  - `meas_valid_o` <= 1.
- **`run` 1→0.**
  - `pcnt`, `phase` and `acc` clear.
  - `vip_o`/`vin_o` go to 0 on the next cycle.
  - `meas_valid_o` clears.
  - `meas_o` holds its value.
- **`run` 0→1.** The first frame starts at `phase` 0 and `pcnt` 0 on the cycle after the write.
- **Reset mid-frame.** Reset aborts the frame. No `frame_o` pulse is produced and `meas_o` is not updated.

## Timing
- **Reset values.** All zero:
  - `vip_o`, `vin_o`, `frame_o`, `meas_o`, `meas_valid_o`
  - `duty_p`, `duty_n`, `presc`, `ctrl`
  - the shadow registers, `pcnt`, `phase`, `acc`
- **Output latency.** `vip_o`/`vin_o` follow `phase` by 1 cycle.
- **Frame length.** 256·(`presc`+1) cycles.
- **`frame_o`.** Asserted in the cycle after the frame-end tick. `meas_o` and `meas_valid_o` update in that same cycle.
- **Sampler latency.** `ota_out` reaches the accumulator 2 cycles after it is registered at `clk`. The measurement window is therefore skewed by 2 cycles relative to the PWM edges, by design.
- **`ena` = 0.** Freezes every register, including the synchronizer. There is no `frame_o` pulse while frozen.
- **Write with `ena` low.** A `cfg_we` pulse while `ena` = 0 is ignored.

## Test plan
- **Reset.** Apply reset, then release with `run` = 0 → all outputs 0. `meas_valid_o` stays 0 for more than 600 cycles.
- **50% PWM.** Write `presc` = 0, `duty_p` = 128, `duty_n` = 64, `run` = 1 → per 256-cycle frame, `vip_o` is high 128 cycles and `vin_o` is high 64 cycles. `frame_o` period is 256 cycles.
- **Loopback.** Drive `ota_out` = `vip_o` with `duty_p` = 100 and `presc` = 3 → `frame_o` every 1024 cycles; second-frame `meas_o` = 100; `meas_valid_o` = 1.
- **Saturation and edges.** `ota_out` tied to 1 → `meas_o` = 255. `duty_p` = 0 → `vip_o` constant 0. `inv_n` = 1 with `duty_n` = 0 → `vin_o` constant 1.
- **Mid-frame write.** Write `duty_p` = 200 at `phase` 50 while running at `duty_p` 10 → the current frame stays at 10 high cycles; the next frame has 200 high cycles. A write landing exactly on the frame-end cycle takes effect in the following frame.
- **Stop/enable.** Clear `run` mid-frame → `vip_o`/`vin_o` drop to 0 next cycle, `meas_valid_o` goes to 0, `meas_o` holds. Hold `ena` = 0 for 100 cycles mid-frame → frame length extends by exactly 100 cycles.

Source files
------------

// File: rtl/ota_stim_meas.sv
// ota_stim_meas: differential PWM stimulus for the OTA plus per-frame high-time readback of its output
module ota_stim_meas #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [7:0]         cfg_data,
    input  logic [1:0]         cfg_sel,
    input  logic               cfg_we,
    input  logic               ota_out,
    output logic               vip_o,
    output logic               vin_o,
    output logic               frame_o,
    output logic [7:0]         meas_o,
    output logic               meas_valid_o
);
    logic [7:0]         duty_p_sh, duty_n_sh, duty_p_act, duty_n_act;
    logic [7:0]         phase, acc, acc_sat;
    logic [8:0]         acc_sum;
    logic [PRESC_W-1:0] presc, pcnt;
    logic [1:0]         sync;
    logic               run, inv_n, tick, frame_end, ota_s;
    logic               wr_p, wr_n, wr_presc, wr_ctrl;

    assign wr_p      = cfg_we && cfg_sel == 2'd0;
    assign wr_n      = cfg_we && cfg_sel == 2'd1;
    assign wr_presc  = cfg_we && cfg_sel == 2'd2;
    assign wr_ctrl   = cfg_we && cfg_sel == 2'd3;
    assign tick      = run && pcnt == presc;
    assign frame_end = tick && phase == 8'hff;
    assign ota_s     = sync[1];
    assign acc_sum   = {1'b0, acc} + {8'd0, ota_s};
    assign acc_sat   = acc_sum[8] ? 8'hff : acc_sum[7:0];

    // Configuration registers; duty values go through shadows so a frame never sees a duty change mid-way
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_p_sh  <= '0;
            duty_n_sh  <= '0;
            duty_p_act <= '0;
            duty_n_act <= '0;
            presc      <= '0;
            run        <= 1'b0;
            inv_n      <= 1'b0;
        end else if (ena) begin
            if (wr_p) duty_p_sh <= cfg_data;
            if (wr_n) duty_n_sh <= cfg_data;
            if (wr_presc) presc <= cfg_data[PRESC_W-1:0];
            if (wr_ctrl) begin
                run   <= cfg_data[0];
                inv_n <= cfg_data[1];
            end
            if (frame_end) duty_p_act <= wr_p ? cfg_data : duty_p_sh;
            else if (!run) duty_p_act <= duty_p_sh;
            if (frame_end) duty_n_act <= wr_n ? cfg_data : duty_n_sh;
            else if (!run) duty_n_act <= duty_n_sh;
        end
    end

    // Prescaler, phase, PWM outputs, synchronizer and measurement accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt         <= '0;
            phase        <= '0;
            acc          <= '0;
            sync         <= '0;
            vip_o        <= 1'b0;
            vin_o        <= 1'b0;
            frame_o      <= 1'b0;
            meas_o       <= '0;
            meas_valid_o <= 1'b0;
        end else begin
            frame_o <= ena && frame_end;
            if (ena) begin
                sync <= {sync[0], ota_out};
                if (!run) begin
                    pcnt         <= '0;
                    phase        <= '0;
                    acc          <= '0;
                    vip_o        <= 1'b0;
                    vin_o        <= 1'b0;
                    meas_valid_o <= 1'b0;
                end else begin
                    vip_o <= phase < duty_p_act;
                    vin_o <= (phase < duty_n_act) ^ inv_n;
                    if (tick) begin
                        pcnt  <= '0;
                        phase <= phase + 8'd1;
                        acc   <= frame_end ? 8'd0 : acc_sat;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                    if (frame_end) begin
                        meas_o       <= acc_sat;
                        meas_valid_o <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
